// File: rtl/tdc_readout_ctrl.sv
// tdc_readout_ctrl
// Sequences the SRAM22 TDC macro through clear, launch and settle. It then
// double-flops the static thermometer code and popcounts it in CHUNKS slices.
// It flags non-thermometer (bubble) codes. Sum, min and max are accumulated
// over N samples and returned through a valid/ready handshake.
//
// Ports:
//   clock, reset      block clock, asynchronous active-high reset
//   req_valid/ready   measurement request handshake (ready only in IDLE)
//   req_samples       sample count N (0 treated as 1)
//   tdc_dout          TDC thermometer code, asynchronous to clock
//   tdc_reset_b       active-low clear to the TDC
//   launch            one-cycle pulse firing the start/stop edge path
//   resp_valid/ready  result handshake
//   resp_sum/min/max  accumulated statistics of the per-sample counts
//   resp_bubble       any sample was a non-thermometer code
//   busy              FSM is not in IDLE
module tdc_readout_ctrl #(
  parameter int DATA_WIDTH    = 252,
  parameter int CHUNKS        = 4,
  parameter int CLEAR_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [7:0]            req_samples,
  input  logic [DATA_WIDTH-1:0] tdc_dout,
  output logic                  tdc_reset_b,
  output logic                  launch,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [15:0]           resp_sum,
  output logic [7:0]            resp_min,
  output logic [7:0]            resp_max,
  output logic                  resp_bubble,
  output logic                  busy
);

  localparam int W = DATA_WIDTH / CHUNKS;
  localparam logic [7:0] CLR_LAST = 8'(CLEAR_CYCLES - 1);
  localparam logic [7:0] SET_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] DEC_LAST = 8'(CHUNKS - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, LAUNCH, SETTLE, SYNC, DECODE, ACCUM, DONE
  } state_t;

  state_t state, state_nxt;
  logic [7:0] cnt;
  logic       started;
  logic [7:0] n_target;
  logic [7:0] k_done;
  logic       accept;

  logic [DATA_WIDTH-1:0] sync_p0;
  logic [DATA_WIDTH-1:0] sync_p1;
  logic [7:0]            count_p2;
  logic                  bubble_p2;

  function automatic logic [7:0] popcount(input logic [W-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + 8'(v[i]);
    return c;
  endfunction

  // A one sitting directly above a zero anywhere breaks the thermometer.
  function automatic logic bubble_of(input logic [DATA_WIDTH-1:0] s);
    return |(s[DATA_WIDTH-1:1] & ~s[DATA_WIDTH-2:0]);
  endfunction

  assign busy   = (state != IDLE);
  assign accept = req_valid && req_ready;

  // started holds req_ready and tdc_reset_b low until the first clock
  // after reset is released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      started <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
      cnt     <= (state_nxt != state) ? 8'd0 : cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    tdc_reset_b = 1'b1;
    launch      = 1'b0;
    resp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready   = started;
        tdc_reset_b = started;
        if (req_valid && started) state_nxt = CLEAR;
      end
      CLEAR: begin
        tdc_reset_b = 1'b0;
        if (cnt == CLR_LAST) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        launch    = 1'b1;
        state_nxt = SETTLE;
      end
      SETTLE: if (cnt == SET_LAST) state_nxt = SYNC;
      SYNC:   if (cnt == 8'd1) state_nxt = DECODE;
      DECODE: if (cnt == DEC_LAST) state_nxt = ACCUM;
      ACCUM:  state_nxt = (k_done + 8'd1 == n_target) ? DONE : CLEAR;
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers keep their values through IDLE until the next accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_sum    <= '0;
      resp_min    <= '0;
      resp_max    <= '0;
      resp_bubble <= 1'b0;
      n_target    <= 8'd1;
      k_done      <= '0;
    end else if (state == IDLE && accept) begin
      n_target    <= (req_samples == 8'd0) ? 8'd1 : req_samples;
      resp_sum    <= '0;
      resp_min    <= 8'hff;
      resp_max    <= '0;
      resp_bubble <= 1'b0;
      k_done      <= '0;
    end else if (state == ACCUM) begin
      resp_sum    <= resp_sum + 16'(count_p2);
      if (count_p2 < resp_min) resp_min <= count_p2;
      if (count_p2 > resp_max) resp_max <= count_p2;
      resp_bubble <= resp_bubble | bubble_p2;
      k_done      <= k_done + 8'd1;
    end
  end

  // Stage p0/p1: two-flop capture, legal because the code is static after settling
  always_ff @(posedge clock) begin
    if (state == SYNC) begin
      sync_p0 <= tdc_dout;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: chunked popcount; bubble flag taken on the first slice
  always_ff @(posedge clock) begin
    if (state == DECODE) begin
      count_p2 <= ((cnt == 8'd0) ? 8'd0 : count_p2) + popcount(sync_p1[int'(cnt)*W +: W]);
      if (cnt == 8'd0) bubble_p2 <= bubble_of(sync_p1);
    end
  end

endmodule

// File: tb/tb_tdc_readout_ctrl.sv
// Testbench for tdc_readout_ctrl: TDC codes are served per launch pulse from
// a table, and results are compared with a reference computed from the codes.
module tb_tdc_readout_ctrl;
  localparam int DW = 252;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [7:0]    req_samples;
  logic [DW-1:0] tdc_dout = '0;
  logic          tdc_reset_b;
  logic          launch;
  logic          resp_valid;
  logic          resp_ready;
  logic [15:0]   resp_sum;
  logic [7:0]    resp_min;
  logic [7:0]    resp_max;
  logic          resp_bubble;
  logic          busy;

  int checks = 0;
  int errors = 0;

  tdc_readout_ctrl dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_samples(req_samples), .tdc_dout(tdc_dout), .tdc_reset_b(tdc_reset_b),
    .launch(launch), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_sum(resp_sum), .resp_min(resp_min), .resp_max(resp_max),
    .resp_bubble(resp_bubble), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Launch number i is answered with code_arr[i].
  logic [DW-1:0] code_arr [0:1023];
  int launch_cnt = 0;
  int last_launch_cyc = 0;
  int clr_low_cnt = 0;
  always @(negedge clock) begin
    if (launch === 1'b1) begin
      launch_cnt      <= launch_cnt + 1;
      last_launch_cyc <= cyc;
      tdc_dout        <= code_arr[launch_cnt % 1024];
    end
    if (busy === 1'b1 && tdc_reset_b === 1'b0) clr_low_cnt <= clr_low_cnt + 1;
  end

  function automatic logic [DW-1:0] therm(input int k);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < k; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Reference: count = number of ones, bubble = any 1 directly above a 0.
  task automatic model(input int base, input int n, output int esum,
                       output int emin, output int emax, output bit ebub);
    int nn;
    nn = (n == 0) ? 1 : n;
    esum = 0; emin = 255; emax = 0; ebub = 1'b0;
    for (int i = 0; i < nn; i++) begin
      logic [DW-1:0] c;
      int k;
      c = code_arr[(base + i) % 1024];
      k = $countones(c);
      esum += k;
      if (k < emin) emin = k;
      if (k > emax) emax = k;
      for (int b = 0; b < DW - 1; b++) if (c[b+1] && !c[b]) ebub = 1'b1;
    end
  endtask

  task automatic do_request(input int samples, input int limit, output int cycles,
                            output int acc_cyc, output bit tmo);
    @(negedge clock);
    req_valid   = 1'b1;
    req_samples = 8'(samples);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    acc_cyc   = cyc;
    tmo       = 1'b0;
    while (resp_valid !== 1'b1) begin
      if (cyc - acc_cyc > limit) begin
        tmo = 1'b1;
        break;
      end
      @(negedge clock);
    end
    cycles = cyc - acc_cyc;
  endtask

  task automatic release_resp();
    @(negedge clock);
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
    checks++; if (tdc_reset_b !== 1'b0) begin errors++; $display("FAIL rst_tdc_reset_b got %b want 0", tdc_reset_b); end
    checks++; if (launch !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_ctrl got launch=%b valid=%b busy=%b want 0", launch, resp_valid, busy); end
    checks++; if (resp_sum !== 16'd0 || resp_min !== 8'd0 || resp_max !== 8'd0 || resp_bubble !== 1'b0) begin errors++; $display("FAIL rst_results got %0d/%0d/%0d/%b want 0", resp_sum, resp_min, resp_max, resp_bubble); end
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_early got %b want 0", req_ready); end
    @(negedge clock);
    checks++; if (req_ready !== 1'b1 || tdc_reset_b !== 1'b1) begin errors++; $display("FAIL rst_idle got ready=%b rb=%b want 1/1", req_ready, tdc_reset_b); end
  endtask

  task automatic test_single();
    int base, cl0, cycles, acc, esum, emin, emax; bit tmo, ebub;
    base = launch_cnt; cl0 = clr_low_cnt;
    code_arr[base % 1024] = therm(100);
    model(base, 1, esum, emin, emax, ebub);
    do_request(1, 100, cycles, acc, tmo);
    checks++; if (tmo || cycles != 18) begin errors++; $display("FAIL single_latency got %0d tmo=%b want 18", cycles, tmo); end
    checks++; if (int'(resp_sum) != esum || esum != 100) begin errors++; $display("FAIL single_sum got %0d want %0d", resp_sum, esum); end
    checks++; if (int'(resp_min) != emin || int'(resp_max) != emax) begin errors++; $display("FAIL single_minmax got %0d/%0d want %0d/%0d", resp_min, resp_max, emin, emax); end
    checks++; if (resp_bubble !== ebub) begin errors++; $display("FAIL single_bubble got %b want %b", resp_bubble, ebub); end
    checks++; if (launch_cnt - base != 1 || last_launch_cyc - acc != 2) begin errors++; $display("FAIL single_launch got n=%0d at +%0d want 1 at +2", launch_cnt - base, last_launch_cyc - acc); end
    checks++; if (clr_low_cnt - cl0 != 2) begin errors++; $display("FAIL single_clear_len got %0d want 2", clr_low_cnt - cl0); end
    release_resp();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL single_release got v=%b r=%b b=%b want 0/1/0", resp_valid, req_ready, busy); end
    checks++; if (int'(resp_sum) != 100) begin errors++; $display("FAIL single_retain got %0d want 100", resp_sum); end
  endtask

  task automatic test_multi();
    int base, cycles, acc; bit tmo;
    base = launch_cnt;
    code_arr[base % 1024]       = therm(40);
    code_arr[(base + 1) % 1024] = therm(42);
    code_arr[(base + 2) % 1024] = therm(44);
    do_request(3, 200, cycles, acc, tmo);
    checks++; if (tmo || cycles != 54) begin errors++; $display("FAIL multi_latency got %0d want 54", cycles); end
    checks++; if (resp_sum !== 16'd126 || resp_min !== 8'd40 || resp_max !== 8'd44) begin errors++; $display("FAIL multi_stats got %0d/%0d/%0d want 126/40/44", resp_sum, resp_min, resp_max); end
    checks++; if (launch_cnt - base != 3) begin errors++; $display("FAIL multi_launches got %0d want 3", launch_cnt - base); end
    release_resp();
  endtask

  task automatic test_bubble();
    int base, cycles, acc; bit tmo;
    logic [DW-1:0] c;
    base = launch_cnt;
    c = therm(10); c[20] = 1'b1;
    code_arr[base % 1024] = c;
    do_request(1, 100, cycles, acc, tmo);
    checks++; if (tmo || resp_sum !== 16'd11 || resp_bubble !== 1'b1) begin errors++; $display("FAIL bubble_code got sum=%0d bub=%b want 11/1", resp_sum, resp_bubble); end
    release_resp();
    base = launch_cnt;
    code_arr[base % 1024] = therm(30);
    do_request(1, 100, cycles, acc, tmo);
    checks++; if (tmo || resp_sum !== 16'd30 || resp_bubble !== 1'b0) begin errors++; $display("FAIL bubble_clean got sum=%0d bub=%b want 30/0", resp_sum, resp_bubble); end
    release_resp();
  endtask

  task automatic test_extremes();
    int base, cycles, acc; bit tmo;
    base = launch_cnt;
    for (int i = 0; i < 255; i++) code_arr[(base + i) % 1024] = therm(252);
    do_request(255, 255 * 18 + 50, cycles, acc, tmo);
    checks++; if (tmo || cycles != 255 * 18) begin errors++; $display("FAIL ones_latency got %0d want %0d", cycles, 255 * 18); end
    checks++; if (resp_sum !== 16'd64260 || resp_min !== 8'd252 || resp_max !== 8'd252 || resp_bubble !== 1'b0) begin errors++; $display("FAIL ones_stats got %0d/%0d/%0d/%b want 64260/252/252/0", resp_sum, resp_min, resp_max, resp_bubble); end
    release_resp();
    base = launch_cnt;
    code_arr[base % 1024] = '0;
    do_request(1, 100, cycles, acc, tmo);
    checks++; if (tmo || resp_sum !== 16'd0 || resp_min !== 8'd0 || resp_max !== 8'd0 || resp_bubble !== 1'b0) begin errors++; $display("FAIL zeros_stats got %0d/%0d/%0d/%b want 0/0/0/0", resp_sum, resp_min, resp_max, resp_bubble); end
    release_resp();
    base = launch_cnt;
    code_arr[base % 1024] = therm(7);
    code_arr[(base + 1) % 1024] = therm(9);
    do_request(0, 100, cycles, acc, tmo);
    checks++; if (tmo || cycles != 18 || launch_cnt - base != 1 || resp_sum !== 16'd7) begin errors++; $display("FAIL zero_samples got cyc=%0d launches=%0d sum=%0d want 18/1/7", cycles, launch_cnt - base, resp_sum); end
    release_resp();
  endtask

  task automatic test_handshake();
    int base, cycles, acc; bit tmo, ready_seen, valid_lost;
    base = launch_cnt;
    code_arr[base % 1024] = therm(60);
    do_request(1, 100, cycles, acc, tmo);
    ready_seen = 1'b0; valid_lost = 1'b0;
    for (int i = 0; i < 50; i++) begin
      req_valid   = (i >= 10 && i < 20);
      req_samples = 8'd3;
      @(negedge clock);
      if (req_ready !== 1'b0) ready_seen = 1'b1;
      if (resp_valid !== 1'b1) valid_lost = 1'b1;
    end
    req_valid = 1'b0;
    checks++; if (tmo || valid_lost) begin errors++; $display("FAIL hold_valid got lost=%b tmo=%b want 0/0", valid_lost, tmo); end
    checks++; if (ready_seen) begin errors++; $display("FAIL hold_req_ready got high want low"); end
    checks++; if (resp_sum !== 16'd60 || resp_min !== 8'd60 || resp_max !== 8'd60) begin errors++; $display("FAIL hold_stable got %0d/%0d/%0d want 60/60/60", resp_sum, resp_min, resp_max); end
    checks++; if (launch_cnt - base != 1 || busy !== 1'b1) begin errors++; $display("FAIL hold_ignored got launches=%0d busy=%b want 1/1", launch_cnt - base, busy); end
    release_resp();
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL hold_release got v=%b b=%b r=%b want 0/0/1", resp_valid, busy, req_ready); end
  endtask

  task automatic test_reset_mid();
    int base, wait_n, cycles, acc; bit tmo;
    base = launch_cnt;
    for (int i = 0; i < 4; i++) code_arr[(base + i) % 1024] = therm(50);
    @(negedge clock);
    req_valid = 1'b1; req_samples = 8'd4;
    @(negedge clock);
    req_valid = 1'b0;
    wait_n = 0;
    while (launch_cnt - base < 2 && wait_n < 100) begin
      @(negedge clock);
      wait_n++;
    end
    checks++; if (wait_n >= 100) begin errors++; $display("FAIL mid_second_launch got timeout want launch"); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || resp_valid !== 1'b0 || tdc_reset_b !== 1'b0 || launch !== 1'b0) begin errors++; $display("FAIL mid_reset got b=%b v=%b rb=%b l=%b want 0/0/0/0", busy, resp_valid, tdc_reset_b, launch); end
    checks++; if (resp_sum !== 16'd0 || resp_max !== 8'd0) begin errors++; $display("FAIL mid_partial got sum=%0d max=%0d want 0/0", resp_sum, resp_max); end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    base = launch_cnt;
    code_arr[base % 1024] = therm(20);
    code_arr[(base + 1) % 1024] = therm(25);
    do_request(2, 100, cycles, acc, tmo);
    checks++; if (tmo || cycles != 36 || resp_sum !== 16'd45 || resp_min !== 8'd20 || resp_max !== 8'd25) begin errors++; $display("FAIL mid_rerun got cyc=%0d %0d/%0d/%0d want 36 45/20/25", cycles, resp_sum, resp_min, resp_max); end
    release_resp();
  endtask

  task automatic test_random();
    int base, n, cycles, acc, esum, emin, emax; bit tmo, ebub;
    for (int it = 0; it < 6; it++) begin
      base = launch_cnt;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        logic [DW-1:0] c;
        c = therm($urandom_range(0, 252));
        if ($urandom_range(0, 3) == 0) c[$urandom_range(0, DW - 1)] = 1'b1;
        code_arr[(base + i) % 1024] = c;
      end
      model(base, n, esum, emin, emax, ebub);
      resp_ready = ($urandom_range(0, 1) == 1);
      do_request(n, 18 * n + 50, cycles, acc, tmo);
      checks++; if (tmo || cycles != 18 * n) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", it, cycles, 18 * n); end
      checks++; if (int'(resp_sum) != esum || int'(resp_min) != emin || int'(resp_max) != emax) begin errors++; $display("FAIL rand%0d_stats got %0d/%0d/%0d want %0d/%0d/%0d", it, resp_sum, resp_min, resp_max, esum, emin, emax); end
      checks++; if (resp_bubble !== ebub || launch_cnt - base != n) begin errors++; $display("FAIL rand%0d_bubble got %b launches=%0d want %b/%0d", it, resp_bubble, launch_cnt - base, ebub, n); end
      release_resp();
    end
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_samples = 8'd0; resp_ready = 1'b0;
    #1 reset = 1'b1;
    test_reset();
    test_single();
    test_multi();
    test_bubble();
    test_extremes();
    test_handshake();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdc_readout_ctrl.md
Name: tdc_readout_ctrl

Overview:
- Downstream consumer of the SRAM22 time-to-digital converter (TDC) macro, sitting between the TDC's 252-bit thermometer output and the BIST/MMIO control path.
- Sequences the macro's active-low clear and a launch pulse for the external start/stop path, then waits for the code to settle.
- Synchronises the static code, converts it to a binary delay count, and flags bubble errors.
- Accumulates the sum, minimum and maximum over a requested number of samples and returns them through a valid/ready handshake.

Parameters:
- DATA_WIDTH, 252, TDC thermometer width.
- CHUNKS, 4, popcount slices processed one per cycle; DATA_WIDTH must divide evenly.
- CLEAR_CYCLES, 2, cycles tdc_reset_b is held low before each launch.
- SETTLE_CYCLES, 8, cycles waited after launch before sampling tdc_dout.

Ports:
- clock  in  1  block clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  measurement request.
- req_ready  out  1  high only in IDLE.
- req_samples  in  8  number of samples; 0 is treated as 1.
- tdc_dout  in  DATA_WIDTH  TDC thermometer code, asynchronous to clock.
- tdc_reset_b  out  1  active-low clear to the TDC.
- launch  out  1  one-cycle pulse that fires the start/stop edge path.
- resp_valid  out  1  result available.
- resp_ready  in  1  result consumed.
- resp_sum  out  16  sum of per-sample counts.
- resp_min  out  8  minimum count.
- resp_max  out  8  maximum count.
- resp_bubble  out  1  any sample was a non-thermometer code.
- busy  out  1  high whenever state is not IDLE.

Behaviour:

Reset values:
- tdc_reset_b=0, launch=0, req_ready=0 during reset, resp_valid=0.
- resp_sum=0, resp_min=0, resp_max=0, resp_bubble=0, busy=0.
- State = IDLE. req_ready rises on the first clock after reset deasserts.

State machine:
- IDLE: req_ready=1; tdc_reset_b=1 (TDC holds last code). On req_valid&req_ready, latch N = max(req_samples,1), clear accumulators (sum=0, min=255, max=0, bubble=0, done count k=0), go to CLEAR.
- CLEAR: tdc_reset_b=0 for CLEAR_CYCLES, then go to LAUNCH.
- LAUNCH: tdc_reset_b=1; launch=1 for exactly one cycle; go to SETTLE.
- SETTLE: count SETTLE_CYCLES, then go to SYNC.
- SYNC: tdc_dout passes through two flop stages. This is legal because the code is static after settling. Takes 2 cycles, then snapshot S is held and the FSM goes to DECODE.
- DECODE: CHUNKS cycles. Cycle j adds popcount(S[j*W +: W]) into an 8-bit count, with W=DATA_WIDTH/CHUNKS. The bubble detector is computed combinationally from S and registered in the first DECODE cycle. Then go to ACCUM.
- ACCUM, one cycle:
  - sum += count (16-bit; cannot overflow for 255×252).
  - min = min(min,count); max = max(max,count).
  - bubble |= bubble_k; k++.
  - If k==N go to DONE, else go to CLEAR.
- DONE: resp_valid=1 with outputs stable. On resp_valid&resp_ready go to IDLE; resp_valid drops the next cycle.

Arithmetic and decode rules:
- Count = number of ones in S, range 0..252.
- Bubble = OR over i of (S[i+1] & ~S[i]) for i in 0..DATA_WIDTH-2; a valid code has ones only in the LSBs.
- Count is still the popcount when a bubble is present (bubble-tolerant).

Latency:
- Per sample: CLEAR_CYCLES + 1 + SETTLE_CYCLES + 2 + CHUNKS + 1 = 18 cycles at defaults.
- From request accept to resp_valid: 18·N cycles.

Boundary conditions:
- req_valid in any state other than IDLE is ignored (req_ready=0).
- resp_ready held high in DONE completes in a single cycle. resp_ready while not in DONE has no effect.
- Result registers retain their last values in IDLE until the next request clears them.
- Asserting reset mid-operation returns to IDLE immediately:
  - tdc_reset_b=0 and launch=0.
  - Partial results are discarded and resp_valid=0.
- An all-zeros code gives count 0 with no bubble. An all-ones code gives count 252 with no bubble.

Test Plan:
- Reset then single request: req_samples=1, tdc_dout=(1<<100)-1 static → tdc_reset_b low 2 cycles, launch pulse at cycle 3, resp_valid at cycle 18, sum=100, min=100, max=100, bubble=0.
- Multi-sample: req_samples=3, bench returns codes with 40, 42 and 44 ones on successive launches → sum=126, min=40, max=44, exactly 3 launch pulses.
- Bubble code: one ones-run of 10 ones plus an isolated bit 20 set → count=11, resp_bubble=1. Next request with a clean code → resp_bubble=0.
- Extremes: all-ones with req_samples=255 → sum=64260, min=max=252. req_samples=0 → exactly one launch, N treated as 1.
- Handshake: resp_ready held low for 50 cycles in DONE → outputs stable, req_ready=0, and a second req_valid is ignored. Raising resp_ready returns to IDLE in 1 cycle.
- Reset mid-operation: assert reset during SETTLE of sample 2 of 4 → next cycle busy=0, resp_valid=0, tdc_reset_b=0. A subsequent request runs cleanly from zeroed accumulators.
